// File: rtl/melody_pkg.sv
// ============================================================================
// Module      : melody_pkg
// Description : Shared tone constants, pitch table and FSM encoding for the
//               score-driven buzzer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package melody_pkg;

   localparam int TONE_W    = 5;
   localparam int TONE_REST = 0;
   localparam int TONE_MAX  = 21;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LATCH = 2'd2,
      ST_PLAY  = 2'd3
   } state_t;

   // C major, three octaves from C4; 1-7 low, 8-14 mid, 15-21 high.
   function automatic int tone_freq(input logic [TONE_W-1:0] tone);
      case (tone)
         5'd1:    return 262;
         5'd2:    return 294;
         5'd3:    return 330;
         5'd4:    return 349;
         5'd5:    return 392;
         5'd6:    return 440;
         5'd7:    return 494;
         5'd8:    return 523;
         5'd9:    return 587;
         5'd10:   return 659;
         5'd11:   return 698;
         5'd12:   return 784;
         5'd13:   return 880;
         5'd14:   return 988;
         5'd15:   return 1046;
         5'd16:   return 1175;
         5'd17:   return 1318;
         5'd18:   return 1397;
         5'd19:   return 1568;
         5'd20:   return 1760;
         5'd21:   return 1976;
         default: return 0;
      endcase
   endfunction

   function automatic int half_period(input logic [TONE_W-1:0] tone, input int clk_hz);
      int f;
      int hp;
      f = tone_freq(tone);
      if (f == 0) return 1;
      hp = (clk_hz + f) / (2 * f);
      return (hp < 1) ? 1 : hp;
   endfunction

endpackage

`default_nettype wire

// File: rtl/melody_player_tone_gen.sv
// ============================================================================
// Module      : tone_gen
// Description : Square-wave generator; half-period looked up per tone index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_gen
   import melody_pkg::*;
#(
   parameter int CLK_HZ = 12_000_000
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic [TONE_W-1:0] tone,
   output logic              wave_o
);

   // Lowest pitch has the longest half period and sets the counter width.
   localparam int c_HP_MAX = half_period(TONE_W'(1), CLK_HZ);
   localparam int c_HP_W   = $clog2(c_HP_MAX + 1);

   logic [c_HP_W-1:0] w_half [0:(2**TONE_W)-1];
   logic [c_HP_W-1:0] w_hp;
   logic [c_HP_W-1:0] r_cnt;
   logic              r_wave;

   generate
      for (genvar gi = 0; gi < 2**TONE_W; gi++) begin : g_table
         localparam logic [c_HP_W-1:0] c_HALF = c_HP_W'(half_period(TONE_W'(gi), CLK_HZ));
         assign w_half[gi] = c_HALF;
      end
   endgenerate

   assign w_hp = w_half[tone];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_wave <= 1'b0;
      end else if (restart) begin
         r_cnt  <= '0;
         r_wave <= 1'b1;
      end else if (r_cnt >= w_hp - c_HP_W'(1)) begin
         r_cnt  <= '0;
         r_wave <= ~r_wave;
      end else begin
         r_cnt  <= r_cnt + c_HP_W'(1);
      end
   end

   assign wave_o = r_wave;

endmodule

`default_nettype wire

// File: rtl/melody_player.sv
// ============================================================================
// Module      : melody_player
// Description : Score ROM sequencer driving a piezo with gapped, tempo-timed notes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_player
   import melody_pkg::*;
#(
   parameter int CLK_HZ      = 12_000_000,
   parameter int UNIT_CYCLES = 750_000,
   parameter int GAP_CYCLES  = 120_000,
   parameter int ADDR_W      = 8,
   parameter int DUR_W       = 4
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    loop_en,
   output logic                    score_rd,
   output logic [ADDR_W-1:0]       score_addr,
   input  logic [TONE_W+DUR_W-1:0] score_data,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_W-1:0]       note_idx,
   output logic                    note_active,
   output logic                    sound_o
);

   localparam int                  c_UNIT_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [c_UNIT_W-1:0] c_UNIT_LAST = c_UNIT_W'(UNIT_CYCLES - 1);
   localparam logic [c_UNIT_W-1:0] c_GAP_START = c_UNIT_W'(UNIT_CYCLES - GAP_CYCLES);
   localparam logic [ADDR_W-1:0]   c_ADDR_LAST = '1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [TONE_W-1:0]   r_tone;
   logic [DUR_W-1:0]    r_dur;
   logic [c_UNIT_W-1:0] r_unit;
   logic [DUR_W-1:0]    r_dcnt;
   logic                r_sound;
   logic [TONE_W-1:0]   w_data_tone;
   logic [DUR_W-1:0]    w_data_dur;
   logic                w_last_unit;
   logic                w_note_end;
   logic                w_in_gap;
   logic                w_tone_ok;
   logic                w_end_mark;
   logic                w_done;
   logic                w_restart;
   logic                w_wave;
   logic                w_active;

   assign w_data_tone = score_data[TONE_W+DUR_W-1:DUR_W];
   assign w_data_dur  = score_data[DUR_W-1:0];
   assign w_last_unit = (r_dcnt == r_dur - DUR_W'(1));
   assign w_note_end  = (r_state == ST_PLAY) && w_last_unit && (r_unit == c_UNIT_LAST);
   assign w_in_gap    = w_last_unit && (r_unit >= c_GAP_START);
   assign w_tone_ok   = (r_tone != TONE_W'(TONE_REST)) && (r_tone <= TONE_W'(TONE_MAX));
   assign w_active    = (r_state == ST_PLAY) && w_tone_ok && !w_in_gap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_done      = 1'b0;
      w_end_mark  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_FETCH;
               w_addr_nxt  = '0;
            end
         end
         ST_FETCH: w_state_nxt = ST_LATCH;
         ST_LATCH: begin
            if (w_data_dur == '0) w_end_mark  = 1'b1;
            else                  w_state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
            if (w_note_end) begin
               if (r_addr == c_ADDR_LAST) begin
                  w_end_mark = 1'b1;
               end else begin
                  w_addr_nxt  = r_addr + ADDR_W'(1);
                  w_state_nxt = ST_FETCH;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // Looping from address 0 would re-fetch an empty song forever.
      if (w_end_mark) begin
         if (loop_en && (r_addr != '0)) begin
            w_addr_nxt  = '0;
            w_state_nxt = ST_FETCH;
         end else begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      end
      if (stop) begin
         w_state_nxt = ST_IDLE;
         w_done      = 1'b0;
      end
   end

   assign w_restart = (r_state == ST_LATCH) && (w_state_nxt == ST_PLAY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_tone  <= '0;
         r_dur   <= '0;
         r_unit  <= '0;
         r_dcnt  <= '0;
         r_sound <= 1'b0;
      end else begin
         r_addr  <= w_addr_nxt;
         r_sound <= w_active && w_wave && !stop;
         if (r_state == ST_LATCH) begin
            r_tone <= w_data_tone;
            r_dur  <= w_data_dur;
            r_unit <= '0;
            r_dcnt <= '0;
         end else if (r_state == ST_PLAY) begin
            if (r_unit == c_UNIT_LAST) begin
               r_unit <= '0;
               r_dcnt <= r_dcnt + DUR_W'(1);
            end else begin
               r_unit <= r_unit + c_UNIT_W'(1);
            end
         end
      end
   end

   tone_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tone_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (w_restart),
      .tone    (r_tone),
      .wave_o  (w_wave)
   );

   assign score_rd    = (r_state == ST_FETCH);
   assign score_addr  = r_addr;
   assign note_idx    = r_addr;
   assign busy        = (r_state != ST_IDLE);
   assign done        = w_done;
   assign note_active = w_active;
   assign sound_o     = r_sound;

endmodule

`default_nettype wire

// File: tb/tb_melody_player.sv
// ============================================================================
// Module      : tb_melody_player
// Description : Directed scoreboard bench for melody_player with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_melody_player;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       loop_en;
   logic       score_rd;
   logic [7:0] score_addr;
   logic [8:0] score_data;
   logic       busy;
   logic       done;
   logic [7:0] note_idx;
   logic       note_active;
   logic       sound_o;

   logic [8:0] rom [256];

   typedef struct {
      int addr;
      int len;
      int act;
      int dn;
      int idx;
   } rec_t;

   rec_t obs_q[$];
   rec_t exp_q[$];
   rec_t cur;
   bit   in_win;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   melody_player #(
      .CLK_HZ      (1_000_000),
      .UNIT_CYCLES (100),
      .GAP_CYCLES  (10),
      .ADDR_W      (8),
      .DUR_W       (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .loop_en     (loop_en),
      .score_rd    (score_rd),
      .score_addr  (score_addr),
      .score_data  (score_data),
      .busy        (busy),
      .done        (done),
      .note_idx    (note_idx),
      .note_active (note_active),
      .sound_o     (sound_o)
   );

   always @(posedge clk) if (score_rd) score_data <= rom[score_addr];

   // One record per fetch window: from a score_rd cycle up to the next fetch or idle.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_win = 1'b0;
      end else begin
         if (in_win && (score_rd || !busy)) begin
            obs_q.push_back(cur);
            in_win = 1'b0;
         end
         if (score_rd) begin
            in_win = 1'b1;
            cur    = '{int'(score_addr), 0, 0, 0, 0};
         end
         if (in_win) begin
            cur.len++;
            if (note_active) cur.act++;
            if (done) cur.dn++;
            cur.idx = int'(note_idx);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_rom(input logic [8:0] w0, input logic [8:0] w1,
                           input logic [8:0] w2, input logic [8:0] w3);
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[0] = w0;
      rom[1] = w1;
      rom[2] = w2;
      rom[3] = w3;
   endtask

   task automatic push_exp(input int addr, input int len, input int act, input int dn);
      exp_q.push_back('{addr, len, act, dn, addr});
   endtask

   task automatic check_recs(input int n);
      rec_t o;
      rec_t e;
      int   k;
      for (int i = 0; i < n; i++) begin
         k = 0;
         while (obs_q.size() == 0 && k < 3000) begin
            @(negedge clk);
            k++;
         end
         chk("window_arrived", (obs_q.size() > 0), 1);
         if (obs_q.size() == 0 || exp_q.size() == 0) return;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk("win_addr", o.addr, e.addr);
         chk("win_len",  o.len,  e.len);
         chk("win_act",  o.act,  e.act);
         chk("win_done", o.dn,   e.dn);
         chk("win_idx",  o.idx,  e.idx);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", busy, 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int hi;
      rst_n   = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_en = 1'b0;
      load_rom('0, '0, '0, '0);

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd", score_rd, 0);
      chk("rst_addr", score_addr, 0);
      chk("rst_idx", note_idx, 0);
      chk("rst_active", note_active, 0);
      chk("rst_sound", sound_o, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Basic note: tone 1 for 2 units, then end marker.
      load_rom({5'd1, 4'd2}, '0, '0, '0);
      push_exp(0, 202, 190, 0);
      push_exp(1, 2, 0, 1);
      pulse_start();
      @(negedge clk);
      chk("start_rd", score_rd, 1);
      chk("start_addr", score_addr, 0);
      check_recs(2);
      wait_idle();

      // Rest and out-of-range tone stay silent.
      load_rom({5'd0, 4'd1}, {5'd25, 4'd1}, {5'd3, 4'd1}, '0);
      push_exp(0, 102, 0, 0);
      push_exp(1, 102, 0, 0);
      push_exp(2, 102, 90, 0);
      push_exp(3, 2, 0, 1);
      pulse_start();
      check_recs(4);
      wait_idle();

      // Loop mode, then release loop_en during a replay.
      load_rom({5'd5, 4'd1}, '0, '0, '0);
      loop_en = 1'b1;
      push_exp(0, 102, 90, 0);
      push_exp(1, 2, 0, 0);
      push_exp(0, 102, 90, 0);
      push_exp(1, 2, 0, 0);
      pulse_start();
      check_recs(4);
      loop_en = 1'b0;
      push_exp(0, 102, 90, 0);
      push_exp(1, 2, 0, 1);
      check_recs(2);
      wait_idle();

      // Empty song with loop_en set must not re-fetch.
      load_rom({5'd7, 4'd0}, '0, '0, '0);
      loop_en = 1'b1;
      push_exp(0, 2, 0, 1);
      pulse_start();
      check_recs(1);
      repeat (20) @(negedge clk);
      chk("empty_no_refetch", obs_q.size(), 0);
      chk("empty_idle", busy, 0);
      loop_en = 1'b0;

      // Stop 50 cycles into the note.
      load_rom({5'd3, 4'd2}, '0, '0, '0);
      push_exp(0, 52, 50, 0);
      pulse_start();
      repeat (51) @(posedge clk);
      #1;
      chk("pre_stop_active", note_active, 1);
      chk("pre_stop_sound", sound_o, 1);
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      @(negedge clk);
      chk("stop_busy", busy, 0);
      chk("stop_active", note_active, 0);
      chk("stop_sound", sound_o, 0);
      chk("stop_done", done, 0);
      check_recs(1);
      push_exp(0, 202, 190, 0);
      push_exp(1, 2, 0, 1);
      pulse_start();
      @(negedge clk);
      chk("restart_addr", score_addr, 0);
      check_recs(2);
      wait_idle();

      // Pitch: mid C at 1 MHz has a 956-cycle half period.
      load_rom({5'd8, 4'd15}, '0, '0, '0);
      push_exp(0, 1502, 1490, 0);
      push_exp(1, 2, 0, 1);
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("play_entry_active", note_active, 1);
      chk("play_entry_sound", sound_o, 0);
      @(negedge clk);
      chk("first_rise", sound_o, 1);
      hi = 0;
      while (sound_o === 1'b1 && hi < 2000) begin
         hi++;
         @(negedge clk);
      end
      chk("half_period", hi, 956);
      check_recs(2);
      wait_idle();

      // Start and stop together: stop wins.
      @(posedge clk); #1 start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("startstop_busy", busy, 0);
      chk("startstop_rd", score_rd, 0);
      repeat (5) @(negedge clk);
      chk("startstop_no_fetch", obs_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
